// File: rtl/cache_controller_assoc_pkg.sv
// cache_pkg: shared state encoding, width and one-hot helpers for the associative cache controller.
package cache_pkg;
   typedef enum logic [1:0] {INIT, IDLE, FILL} state_e;
   function automatic int way_width(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction
   function automatic logic [7:0] onehot(input logic [2:0] w);
      return 8'b1 << w;
   endfunction
endpackage

// File: rtl/cache_controller_assoc_if.sv
// cache_controller_assoc_if: request, array and memory signals between core/arrays and the controller.
interface cache_controller_assoc_if #(
   parameter int TAG_WIDTH = 3,
   parameter int INDEX_WIDTH = 5,
   parameter int BLOCK_WIDTH = 2,
   parameter int WAYS = 4
);
   logic                   i_rd;
   logic                   i_flush;
   logic [TAG_WIDTH-1:0]   i_tag;
   logic [INDEX_WIDTH-1:0] i_index;
   logic [BLOCK_WIDTH-1:0] i_block;
   logic [WAYS-1:0]        i_hit_way;
   logic                   i_mem_ack;
   logic [TAG_WIDTH-1:0]   o_tag;
   logic [INDEX_WIDTH-1:0] o_index;
   logic [BLOCK_WIDTH-1:0] o_block;
   logic [WAYS-1:0]        o_way;
   logic                   o_wr;
   logic                   o_cl;
   logic                   o_mem_req;
   logic                   o_hit;
   logic                   o_busy;
   modport slave (
      input  i_rd, i_flush, i_tag, i_index, i_block, i_hit_way, i_mem_ack,
      output o_tag, o_index, o_block, o_way, o_wr, o_cl, o_mem_req, o_hit, o_busy
   );
   modport master (
      output i_rd, i_flush, i_tag, i_index, i_block, i_hit_way, i_mem_ack,
      input  o_tag, o_index, o_block, o_way, o_wr, o_cl, o_mem_req, o_hit, o_busy
   );
endinterface

// File: rtl/cache_controller_assoc_replacement.sv
// cache_replacement: per-set round-robin victim pointers, async read, sync clear.
module cache_replacement
   import cache_pkg::*;
#(
   parameter int INDEX_WIDTH = 5,
   parameter int WAYS = 4,
   localparam int WAY_WIDTH = way_width(WAYS)
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_clear,
   input  logic [INDEX_WIDTH-1:0] i_index,
   input  logic                   i_advance,
   output logic [WAY_WIDTH-1:0]   o_victim
);
   logic [WAY_WIDTH-1:0] ptr_q [2**INDEX_WIDTH];
   // a single way has nothing to rotate through, so its pointer stays at 0
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) ptr_q <= '{default: '0};
      else if (i_clear) ptr_q <= '{default: '0};
      else if (i_advance) ptr_q[i_index] <= (WAYS == 1) ? '0 : ptr_q[i_index] + 1'b1;
   assign o_victim = ptr_q[i_index];
endmodule

// File: rtl/cache_controller_assoc.sv
// cache_controller_assoc: N-way read-only cache controller; clear sweep, hit report, block refill on miss.
module cache_controller_assoc
   import cache_pkg::*;
#(
   parameter int TAG_WIDTH = 3,
   parameter int INDEX_WIDTH = 5,
   parameter int BLOCK_WIDTH = 2,
   parameter int WAYS = 4,
   localparam int WAY_WIDTH = way_width(WAYS)
) (
   input logic i_clock,
   input logic i_reset,
   cache_controller_assoc_if.slave bus
);
   state_e                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] cnt_q, cnt_d, index_q, index_d;
   logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [WAY_WIDTH-1:0]   victim_q, victim_d, victim;
   logic                   pend_q, pend_d, advance;
   cache_replacement #(.INDEX_WIDTH(INDEX_WIDTH), .WAYS(WAYS)) u_repl (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (state_q == INIT),
      .i_index  (state_q == FILL ? index_q : bus.i_index),
      .i_advance(advance),
      .o_victim (victim)
   );
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         blk_q    <= '0;
         tag_q    <= '0;
         index_q  <= '0;
         victim_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         blk_q    <= blk_d;
         tag_q    <= tag_d;
         index_q  <= index_d;
         victim_q <= victim_d;
         pend_q   <= pend_d;
      end
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      blk_d    = blk_q;
      tag_d    = tag_q;
      index_d  = index_q;
      victim_d = victim_q;
      pend_d   = pend_q;
      advance  = 1'b0;
      case (state_q)
         INIT: begin
            cnt_d   = cnt_q + 1'b1;
            pend_d  = 1'b0;
            state_d = &cnt_q ? IDLE : INIT;
         end
         IDLE:
            if (bus.i_flush) begin
               state_d = INIT;
               cnt_d   = '0;
            end else if (bus.i_rd && !(|bus.i_hit_way)) begin
               state_d  = FILL;
               tag_d    = bus.i_tag;
               index_d  = bus.i_index;
               victim_d = victim;
               blk_d    = '0;
            end
         FILL: begin
            // a flush arriving with the final ack still counts as pending
            pend_d = pend_q | bus.i_flush;
            if (bus.i_mem_ack) begin
               blk_d = blk_q + 1'b1;
               if (&blk_q) begin
                  advance = 1'b1;
                  state_d = pend_d ? INIT : IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = INIT;
      endcase
   end
   always_comb begin
      bus.o_tag     = bus.i_tag;
      bus.o_index   = bus.i_index;
      bus.o_block   = bus.i_block;
      bus.o_way     = '0;
      bus.o_wr      = 1'b0;
      bus.o_cl      = 1'b0;
      bus.o_mem_req = 1'b0;
      bus.o_hit     = 1'b0;
      bus.o_busy    = 1'b1;
      case (state_q)
         INIT: begin
            bus.o_cl    = 1'b1;
            bus.o_way   = '1;
            bus.o_index = cnt_q;
         end
         IDLE: begin
            bus.o_busy = 1'b0;
            bus.o_hit  = |bus.i_hit_way;
         end
         FILL: begin
            bus.o_tag     = tag_q;
            bus.o_index   = index_q;
            bus.o_block   = blk_q;
            bus.o_way     = WAYS'(onehot(3'(victim_q)));
            bus.o_wr      = bus.i_mem_ack;
            bus.o_mem_req = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_controller_assoc.sv
// tb_cache_controller_assoc: directed scoreboard bench for the associative cache controller.
module tb_cache_controller_assoc;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   cache_controller_assoc_if #(.TAG_WIDTH(3), .INDEX_WIDTH(5), .BLOCK_WIDTH(2), .WAYS(4)) bus ();
   cache_controller_assoc #(.TAG_WIDTH(3), .INDEX_WIDTH(5), .BLOCK_WIDTH(2), .WAYS(4)) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus    (bus)
   );
   typedef struct {
      string       n;
      logic [18:0] v;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int rr[32];
   function automatic logic [3:0] way_of(input logic [4:0] ix);
      return 4'(1 << rr[ix]);
   endfunction
   task automatic clear_rr();
      for (int i = 0; i < 32; i++) rr[i] = 0;
   endtask
   task automatic set_in(input logic rd, fl, input logic [2:0] tg, input logic [4:0] ix,
                         input logic [1:0] bk, input logic [3:0] hw, input logic ack);
      bus.i_rd = rd;
      bus.i_flush = fl;
      bus.i_tag = tg;
      bus.i_index = ix;
      bus.i_block = bk;
      bus.i_hit_way = hw;
      bus.i_mem_ack = ack;
   endtask
   task automatic nx(input logic rd, fl, input logic [2:0] tg, input logic [4:0] ix,
                     input logic [1:0] bk, input logic [3:0] hw, input logic ack);
      @(negedge clk);
      set_in(rd, fl, tg, ix, bk, hw, ack);
   endtask
   task automatic ex(input string n, input logic cl, wr, req, hit, busy, input logic [3:0] way,
                     input logic [4:0] ix, input logic [1:0] bk, input logic [2:0] tg);
      exp_t e;
      logic [18:0] act;
      q.push_back('{n, {cl, wr, req, hit, busy, way, ix, bk, tg}});
      #1;
      e = q.pop_front();
      act = {bus.o_cl, bus.o_wr, bus.o_mem_req, bus.o_hit, bus.o_busy, bus.o_way, bus.o_index, bus.o_block, bus.o_tag};
      checks++;
      assert (act === e.v) else begin
         failures++;
         $error("FAIL %s got cl/wr/req/hit/busy/way/idx/blk/tag=%b expected=%b", e.n, act, e.v);
      end
   endtask
   task automatic sweep();
      set_in(0, 0, 0, 0, 0, 0, 0);
      ex("init_sweep", 1, 0, 0, 0, 1, 4'hf, 0, 0, 0);
      for (int k = 1; k < 32; k++) begin
         nx(0, 0, 0, 0, 0, 0, 0);
         ex("init_sweep", 1, 0, 0, 0, 1, 4'hf, 5'(k), 0, 0);
      end
      clear_rr();
      nx(0, 0, 0, 0, 0, 0, 0);
      ex("init_done", 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic miss(input logic [2:0] tg, input logic [4:0] ix, input logic [1:0] bk);
      logic [3:0] w;
      w = way_of(ix);
      nx(1, 0, tg, ix, bk, 0, 0);
      ex("miss_detect", 0, 0, 0, 0, 0, 0, ix, bk, tg);
      for (int b = 0; b < 4; b++) begin
         nx(0, 0, 0, 0, 0, 0, 1);
         ex("fill_word", 0, 1, 1, 0, 1, w, ix, 2'(b), tg);
      end
      rr[ix] = (rr[ix] + 1) % 4;
      nx(1, 0, tg, ix, bk, w, 0);
      ex("rehit", 0, 0, 0, 1, 0, 0, ix, bk, tg);
   endtask
   initial begin
      logic pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      logic [1:0] b;
      clear_rr();
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      ex("reset_out", 1, 0, 0, 0, 1, 4'hf, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      sweep();
      nx(1, 0, 3'd5, 5'd3, 2'd2, 4'b0100, 1);
      ex("hit", 0, 0, 0, 1, 0, 0, 3, 2, 5);
      nx(1, 0, 3'd5, 5'd3, 2'd2, 4'b0100, 0);
      ex("hit_stays_idle", 0, 0, 0, 1, 0, 0, 3, 2, 5);
      for (int i = 0; i < 5; i++) miss(3'd5, 5'd3, 2'd0);
      nx(1, 0, 3'd2, 5'd7, 2'd1, 0, 0);
      ex("ackpat_detect", 0, 0, 0, 0, 0, 0, 7, 1, 2);
      b = 0;
      for (int i = 0; i < 7; i++) begin
         nx(0, 0, 0, 0, 0, 0, pat[i]);
         ex("ackpat_fill", 0, pat[i], 1, 0, 1, 4'b0001, 7, b, 2);
         if (pat[i]) b = b + 1'b1;
      end
      rr[7] = 1;
      nx(0, 0, 0, 0, 0, 0, 0);
      ex("ackpat_done", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nx(1, 0, 3'd1, 5'd9, 2'd0, 0, 0);
      ex("flfill_detect", 0, 0, 0, 0, 0, 0, 9, 0, 1);
      nx(0, 0, 0, 0, 0, 0, 1);
      ex("flfill_w0", 0, 1, 1, 0, 1, 4'b0001, 9, 0, 1);
      nx(0, 1, 0, 0, 0, 0, 0);
      ex("flfill_flush", 0, 0, 1, 0, 1, 4'b0001, 9, 1, 1);
      for (int k = 1; k < 4; k++) begin
         nx(0, 0, 0, 0, 0, 0, 1);
         ex("flfill_wk", 0, 1, 1, 0, 1, 4'b0001, 9, 2'(k), 1);
      end
      @(negedge clk);
      sweep();
      nx(1, 1, 3'd6, 5'd3, 2'd1, 0, 0);
      ex("flush_rd_idle", 0, 0, 0, 0, 0, 0, 3, 1, 6);
      @(negedge clk);
      sweep();
      miss(3'd2, 5'd3, 2'd0);
      nx(1, 0, 3'd4, 5'd3, 2'd0, 0, 0);
      ex("rstfill_detect", 0, 0, 0, 0, 0, 0, 3, 0, 4);
      for (int k = 0; k < 2; k++) begin
         nx(0, 0, 0, 0, 0, 0, 1);
         ex("rstfill_w", 0, 1, 1, 0, 1, 4'b0010, 3, 2'(k), 4);
      end
      nx(0, 0, 0, 0, 0, 0, 0);
      ex("rstfill_b2", 0, 0, 1, 0, 1, 4'b0010, 3, 2, 4);
      rst = 1'b1;
      ex("rst_midcycle", 1, 0, 0, 0, 1, 4'hf, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      sweep();
      miss(3'd4, 5'd3, 2'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
